// File: rtl/alu_bus_initiator.sv
// -----------------------------------------------------------------------------
// alu_bus_initiator
//
// Purpose:
//   Bus initiator for the integer ALU peripheral on the shared system bus.
//   It takes one arithmetic request at a time and runs the fixed bus sequence:
//   write source 1, write source 2, write command, then read the result.
//   It returns the 16-bit result on a valid/ready response handshake.
//   A divide by zero is answered locally with 16'hFFFF and the error flag, and
//   never touches the bus.
//
// Ports:
//   clk         clock; all state changes on posedge
//   nReset      asynchronous active-low reset
//   req_valid   request present
//   req_ready   initiator idle; request accepted on posedge when both high
//   req_op      0 add, 1 sub, 2 mul, 3 div
//   req_a       source 1 operand
//   req_b       source 2 operand
//   rsp_valid   result available
//   rsp_ready   consumer takes result on posedge when both high
//   rsp_result  16-bit result
//   rsp_err     divide-by-zero flag, valid with rsp_valid
//   addr        bus address {peripheral id, register offset}
//   nRead       bus read strobe, active low
//   nWrite      bus write strobe, active low
//   bus         shared bidirectional data bus
// -----------------------------------------------------------------------------
module alu_bus_initiator #(
    parameter int PERIPH_ID = 5,
    parameter int BUS_W     = 256,
    parameter int DATA_W    = 16,
    parameter int OFS_SRC1  = 0,
    parameter int OFS_SRC2  = 1,
    parameter int OFS_CMD   = 3,
    parameter int OFS_RES   = 2
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_err,
    output logic [15:0]       addr,
    output logic              nRead,
    output logic              nWrite,
    inout  wire  [BUS_W-1:0]  bus
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] WR_A   = 3'd1;
    localparam logic [2:0] WR_B   = 3'd2;
    localparam logic [2:0] WR_CMD = 3'd3;
    localparam logic [2:0] RD     = 3'd4;
    localparam logic [2:0] RESP   = 3'd5;

    localparam logic [1:0] OP_DIV = 2'd3;

    localparam logic [15:0] ADDR_IDLE = 16'h0000;
    localparam logic [15:0] ADDR_SRC1 = {4'(PERIPH_ID), 12'(OFS_SRC1)};
    localparam logic [15:0] ADDR_SRC2 = {4'(PERIPH_ID), 12'(OFS_SRC2)};
    localparam logic [15:0] ADDR_CMD  = {4'(PERIPH_ID), 12'(OFS_CMD)};
    localparam logic [15:0] ADDR_RES  = {4'(PERIPH_ID), 12'(OFS_RES)};

    logic [2:0]        state_reg;
    logic [DATA_W-1:0] b_reg;
    logic [1:0]        op_reg;
    logic [DATA_W-1:0] drive_data_reg;
    logic              drive_en_reg;
    logic [15:0]       addr_reg;
    logic              n_read_reg;
    logic              n_write_reg;
    logic              rsp_valid_reg;
    logic [DATA_W-1:0] rsp_result_reg;
    logic              rsp_err_reg;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_reg      <= IDLE;
            b_reg          <= '0;
            op_reg         <= '0;
            drive_data_reg <= '0;
            drive_en_reg   <= 1'b0;
            addr_reg       <= ADDR_IDLE;
            n_read_reg     <= 1'b1;
            n_write_reg    <= 1'b1;
            rsp_valid_reg  <= 1'b0;
            rsp_result_reg <= '0;
            rsp_err_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        // Operand A goes straight onto the bus, so only B
                        // and the opcode need to be held for later cycles.
                        b_reg  <= req_b;
                        op_reg <= req_op;
                        if (req_op == OP_DIV && req_b == '0) begin
                            state_reg      <= RESP;
                            rsp_valid_reg  <= 1'b1;
                            rsp_result_reg <= '1;
                            rsp_err_reg    <= 1'b1;
                        end else begin
                            state_reg      <= WR_A;
                            addr_reg       <= ADDR_SRC1;
                            n_write_reg    <= 1'b0;
                            drive_en_reg   <= 1'b1;
                            drive_data_reg <= req_a;
                        end
                    end
                end
                WR_A: begin
                    state_reg      <= WR_B;
                    addr_reg       <= ADDR_SRC2;
                    drive_data_reg <= b_reg;
                end
                WR_B: begin
                    state_reg      <= WR_CMD;
                    addr_reg       <= ADDR_CMD;
                    // The peripheral decodes the whole bus word as the
                    // command, so everything above the opcode must be zero.
                    drive_data_reg <= {{(DATA_W-2){1'b0}}, op_reg};
                end
                WR_CMD: begin
                    state_reg    <= RD;
                    addr_reg     <= ADDR_RES;
                    n_write_reg  <= 1'b1;
                    n_read_reg   <= 1'b0;
                    drive_en_reg <= 1'b0;
                end
                RD: begin
                    // The peripheral keeps driving while its address is
                    // selected, so the address must return to the reserved
                    // idle id here. The RESP cycle that follows gives it time
                    // to release the bus before the next write.
                    state_reg      <= RESP;
                    rsp_result_reg <= bus[DATA_W-1:0];
                    rsp_err_reg    <= 1'b0;
                    rsp_valid_reg  <= 1'b1;
                    addr_reg       <= ADDR_IDLE;
                    n_read_reg     <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_reg     <= IDLE;
                        rsp_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus = drive_en_reg ? {{(BUS_W-DATA_W){1'b0}}, drive_data_reg}
                              : {BUS_W{1'bz}};

    assign req_ready  = (state_reg == IDLE);
    assign rsp_valid  = rsp_valid_reg;
    assign rsp_result = rsp_result_reg;
    assign rsp_err    = rsp_err_reg;
    assign addr       = addr_reg;
    assign nRead      = n_read_reg;
    assign nWrite     = n_write_reg;

endmodule

// File: tb/tb_alu_bus_initiator.sv
// -----------------------------------------------------------------------------
// tb_alu_bus_initiator
//
// Bench for alu_bus_initiator. A small ALU peripheral model sits on the bus:
// it samples writes on negedge, and it drives the result while its result
// address is selected. Expected results come from plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_alu_bus_initiator;

    logic         clk;
    logic         nReset;
    logic         req_valid;
    logic         req_ready;
    logic [1:0]   req_op;
    logic [15:0]  req_a;
    logic [15:0]  req_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [15:0]  rsp_result;
    logic         rsp_err;
    logic [15:0]  addr;
    logic         nRead;
    logic         nWrite;
    wire  [255:0] bus;

    int total = 0;
    int bad   = 0;
    int contention = 0;

    alu_bus_initiator dut (
        .clk        (clk),
        .nReset     (nReset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .addr       (addr),
        .nRead      (nRead),
        .nWrite     (nWrite),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- peripheral model ----------------
    logic [15:0]  per_src1 = '0;
    logic [15:0]  per_src2 = '0;
    logic [255:0] per_cmd  = '0;
    logic         per_drive = 1'b0;
    logic [15:0]  per_out;

    logic [15:0] wlog_addr[$];
    logic [15:0] wlog_data[$];
    logic        wlog_hi[$];

    always_comb begin
        per_out = 16'hBAD0;
        if (per_cmd[255:2] == '0) begin
            case (per_cmd[1:0])
                2'd0: per_out = per_src1 + per_src2;
                2'd1: per_out = per_src1 - per_src2;
                2'd2: per_out = per_src1 * per_src2;
                default: per_out = (per_src2 == 0) ? 16'hBAD1 : per_src1 / per_src2;
            endcase
        end
    end

    assign bus = per_drive ? {240'b0, per_out} : {256{1'bz}};

    always @(negedge clk) begin
        if (per_drive && !nWrite) contention++;
        if (!nRead && !nWrite) contention++;
        if (!nWrite && addr[15:12] == 4'd5) begin
            case (addr[11:0])
                12'd0: per_src1 <= bus[15:0];
                12'd1: per_src2 <= bus[15:0];
                12'd3: per_cmd  <= bus;
                default: ;
            endcase
            wlog_addr.push_back(addr);
            wlog_data.push_back(bus[15:0]);
            wlog_hi.push_back(|bus[255:16]);
        end
        per_drive <= (addr == 16'h5002);
    end

    // ---------------- reference model ----------------
    function automatic logic [15:0] model(input int op, input longint unsigned a,
                                          input longint unsigned b);
        longint unsigned r;
        case (op)
            0: r = (a + b) % 65536;
            1: r = (a + 65536 - b) % 65536;
            2: r = (a * b) % 65536;
            default: r = (b == 0) ? 65535 : a / b;
        endcase
        return r[15:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        req_op = 2'($urandom);
        req_a  = 16'($urandom);
        req_b  = 16'($urandom);
    endtask

    // One full request: issue, follow the bus sequence, hold the response for
    // 'hold' cycles, then release. With 'noise' set, req_valid stays high with
    // unrelated operands while the initiator is busy.
    task automatic run_req(input logic [1:0] op, input logic [15:0] a,
                           input logic [15:0] b, input int hold, input bit noise);
        logic [15:0] exp_res;
        logic [15:0] exp_addr[4];
        logic [15:0] exp_wdata[3];
        bit dz;
        exp_addr  = '{16'h5000, 16'h5001, 16'h5003, 16'h5002};
        exp_wdata = '{a, b, {14'b0, op}};
        dz      = (op == 2'd3) && (b == 16'd0);
        exp_res = dz ? 16'hFFFF : model(int'(op), longint'(a), longint'(b));

        chk("idle_req_ready", req_ready, 1);
        req_valid = 1'b1;
        req_op = op; req_a = a; req_b = b;
        step();                                   // E0
        req_valid = noise;
        scramble();
        if (!dz) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("addr_E%0d", k), addr, exp_addr[k]);
                chk($sformatf("nWrite_E%0d", k), nWrite, (k == 3) ? 1 : 0);
                chk($sformatf("nRead_E%0d", k), nRead, (k == 3) ? 0 : 1);
                chk($sformatf("rsp_valid_early_E%0d", k), rsp_valid, 0);
                chk($sformatf("busy_req_ready_E%0d", k), req_ready, 0);
                step();
                if (noise) scramble();
            end
        end
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_result", rsp_result, exp_res);
        chk("rsp_err", rsp_err, dz);
        chk("resp_addr", addr, 16'h0000);
        chk("resp_nRead", nRead, 1);
        chk("resp_nWrite", nWrite, 1);
        chk("resp_req_ready", req_ready, 0);
        if (dz) begin
            chk("dz_no_writes", wlog_addr.size(), 0);
        end else begin
            chk("write_count", wlog_addr.size(), 3);
            for (int i = 0; i < 3 && wlog_addr.size() > 0; i++) begin
                chk($sformatf("wr%0d_addr", i), wlog_addr.pop_front(), exp_addr[i]);
                chk($sformatf("wr%0d_data", i), wlog_data.pop_front(), exp_wdata[i]);
                chk($sformatf("wr%0d_upper", i), wlog_hi.pop_front(), 0);
            end
        end
        wlog_addr.delete(); wlog_data.delete(); wlog_hi.delete();
        for (int h = 0; h < hold; h++) begin
            rsp_ready = 1'b0;
            step();
            chk("hold_rsp_valid", rsp_valid, 1);
            chk("hold_rsp_result", rsp_result, exp_res);
            chk("hold_rsp_err", rsp_err, dz);
            chk("hold_req_ready", req_ready, 0);
            chk("hold_addr", addr, 16'h0000);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        step();                                   // response taken
        rsp_ready = 1'b0;
        chk("release_rsp_valid", rsp_valid, 0);
        chk("release_req_ready", req_ready, 1);
        $display("txn op=%0d a=%h b=%h result=%h err=%0d hold=%0d noise=%0d",
                 op, a, b, exp_res, dz, hold, noise);
    endtask

    initial begin
        nReset    = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        req_op = '0; req_a = '0; req_b = '0;
        #12;
        chk("rst_addr", addr, 16'h0000);
        chk("rst_nRead", nRead, 1);
        chk("rst_nWrite", nWrite, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_req_ready", req_ready, 1);
        step();
        nReset = 1'b1;
        step();

        run_req(2'd0, 16'd7,   16'd5,   0, 0);
        run_req(2'd1, 16'd3,   16'd5,   1, 0);
        run_req(2'd2, 16'd300, 16'd300, 0, 0);
        run_req(2'd3, 16'd100, 16'd7,   2, 0);
        run_req(2'd3, 16'd9,   16'd0,   0, 0);
        run_req(2'd0, 16'd1234, 16'd4321, 3, 1);
        run_req(2'd3, 16'd50,  16'd0,   3, 1);

        // Asynchronous reset while the command write is on the bus.
        req_valid = 1'b1; req_op = 2'd2; req_a = 16'd11; req_b = 16'd13;
        step();                                   // E0
        req_valid = 1'b0;
        step();                                   // E1
        step();                                   // E2: command write
        chk("pre_rst_nWrite", nWrite, 0);
        #2 nReset = 1'b0;
        #1;
        chk("midrst_addr", addr, 16'h0000);
        chk("midrst_nWrite", nWrite, 1);
        chk("midrst_nRead", nRead, 1);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_req_ready", req_ready, 1);
        step();
        nReset = 1'b1;
        wlog_addr.delete(); wlog_data.delete(); wlog_hi.delete();
        step();
        run_req(2'd0, 16'd1, 16'd1, 0, 0);

        for (int t = 0; t < 20; t++) begin
            logic [1:0]  op;
            logic [15:0] a;
            logic [15:0] b;
            op = 2'($urandom_range(0, 3));
            a  = 16'($urandom);
            b  = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom);
            run_req(op, a, b, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
        end

        chk("bus_contention", contention, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
